accel_spi_responder: RTL and testbench

ACCEL_SPI_RESPONDER -- requirements
Module: accel_spi_responder

---
 rtl/accel_spi_responder.sv | 207 ++++++++++++++++++++
 tb/tb_accel_spi_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_spi_responder.sv
// SPI mode-0 responder for an accelerometer-style register file.
// All SPI pins are oversampled by the system clock; SCLK edges come from the synchronized level.
module accel_spi_responder #(
    parameter logic [7:0] DEVID  = 8'hAD,
    parameter logic [7:0] PARTID = 8'hF2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CS,
    input  logic        SCLK,
    input  logic        SDI,
    output logic        SDO,
    input  logic [11:0] x_data,
    input  logic [11:0] y_data,
    input  logic [11:0] z_data,
    output logic        wr_valid,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StRead,
        StWrite,
        StIgnore
    } state_e;

    state_e state_q, state_d;

    logic       cs_meta, cs_sync;
    logic       sclk_meta, sclk_sync, sclk_prev;
    logic       sdi_meta, sdi_sync;
    logic [1:0] fill_q;
    logic       armed_q;

    logic [2:0]  bit_cnt_q;
    logic [7:0]  shreg_q;
    logic [6:0]  tx_q;
    logic        sdo_q;
    logic        is_write_q;
    logic [7:0]  ptr_q;
    logic [11:0] snap_x, snap_y, snap_z;
    logic [7:0]  bank [16];

    logic       sclk_rise, sclk_fall;
    logic       cs_start, cs_end;
    logic       byte_done;
    logic [7:0] rx_byte;
    logic [7:0] rd_byte;

    // Pin synchronizers; armed_q only rises once CS has been seen high from real pin samples,
    // so a reset taken with CS held low cannot start a transaction from stale reset values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            sdi_meta  <= 1'b0;
            sdi_sync  <= 1'b0;
            fill_q    <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            cs_meta   <= CS;
            cs_sync   <= cs_meta;
            sclk_meta <= SCLK;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            sdi_meta  <= SDI;
            sdi_sync  <= sdi_meta;
            fill_q    <= {fill_q[0], 1'b1};
            if (cs_start) begin
                armed_q <= 1'b0;
            end else if (fill_q[1] && cs_sync) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign sclk_rise = sclk_sync & ~sclk_prev;
    assign sclk_fall = ~sclk_sync & sclk_prev;
    assign cs_start  = (state_q == StIdle) & armed_q & ~cs_sync;
    assign cs_end    = (state_q != StIdle) & cs_sync;
    assign byte_done = sclk_rise & (bit_cnt_q == 3'd7);
    assign rx_byte   = {shreg_q[6:0], sdi_sync};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; CS release overrides any byte completing in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (cs_start) state_d = StCmd;
            end
            StCmd: begin
                if (byte_done) begin
                    if (rx_byte == 8'h0B || rx_byte == 8'h0A) state_d = StAddr;
                    else                                      state_d = StIgnore;
                end
            end
            StAddr: begin
                if (byte_done) state_d = is_write_q ? StWrite : StRead;
            end
            default: ;
        endcase
        if (cs_end) state_d = StIdle;
    end

    // Outputs: busy tracks framing, read data is decoded from the pointer
    always_comb begin
        busy    = (state_q != StIdle);
        rd_byte = 8'h00;
        case (ptr_q)
            8'h00:   rd_byte = DEVID;
            8'h02:   rd_byte = PARTID;
            8'h0E:   rd_byte = snap_x[7:0];
            8'h0F:   rd_byte = {{4{snap_x[11]}}, snap_x[11:8]};
            8'h10:   rd_byte = snap_y[7:0];
            8'h11:   rd_byte = {{4{snap_y[11]}}, snap_y[11:8]};
            8'h12:   rd_byte = snap_z[7:0];
            8'h13:   rd_byte = {{4{snap_z[11]}}, snap_z[11:8]};
            default: if (ptr_q[7:4] == 4'h2) rd_byte = bank[ptr_q[3:0]];
        endcase
    end

    // Datapath: bit shifting, pointer, register bank, SDO and write strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q  <= 3'd0;
            shreg_q    <= 8'h00;
            tx_q       <= 7'h00;
            sdo_q      <= 1'b0;
            is_write_q <= 1'b0;
            ptr_q      <= 8'h00;
            snap_x     <= 12'h000;
            snap_y     <= 12'h000;
            snap_z     <= 12'h000;
            wr_valid   <= 1'b0;
            wr_addr    <= 8'h00;
            wr_data    <= 8'h00;
            for (int i = 0; i < 16; i++) bank[i] <= 8'h00;
        end else begin
            wr_valid <= 1'b0;
            if (cs_end || state_q == StIdle) begin
                bit_cnt_q <= 3'd0;
                sdo_q     <= 1'b0;
                if (cs_start) begin
                    snap_x <= x_data;
                    snap_y <= y_data;
                    snap_z <= z_data;
                end
            end else begin
                if (sclk_rise) begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    shreg_q   <= rx_byte;
                end
                case (state_q)
                    StCmd: begin
                        if (byte_done) is_write_q <= (rx_byte == 8'h0A);
                    end
                    StAddr: begin
                        if (byte_done) ptr_q <= rx_byte;
                    end
                    StRead: begin
                        if (byte_done) ptr_q <= ptr_q + 8'd1;
                        // Bit counter at zero on a fall means a fresh byte starts here
                        if (sclk_fall) begin
                            if (bit_cnt_q == 3'd0) begin
                                sdo_q <= rd_byte[7];
                                tx_q  <= rd_byte[6:0];
                            end else begin
                                sdo_q <= tx_q[6];
                                tx_q  <= {tx_q[5:0], 1'b0};
                            end
                        end
                    end
                    StWrite: begin
                        if (byte_done) begin
                            wr_valid <= 1'b1;
                            wr_addr  <= ptr_q;
                            wr_data  <= rx_byte;
                            if (ptr_q[7:4] == 4'h2) bank[ptr_q[3:0]] <= rx_byte;
                            ptr_q <= ptr_q + 8'd1;
                        end
                    end
                    default: ;
                endcase
                if (state_q != StRead) sdo_q <= 1'b0;
            end
        end
    end

    assign SDO = sdo_q;

endmodule

// File: tb/tb_accel_spi_responder.sv
// Bench for accel_spi_responder: directed vector table, corner sequences and
// randomized transactions checked against a register-map model.
module tb_accel_spi_responder;

    localparam int Half = 5;  // SCLK half period in clk cycles

    logic        clk = 1'b0;
    logic        reset, CS, SCLK, SDI, SDO;
    logic [11:0] x_data, y_data, z_data;
    logic        wr_valid, busy;
    logic [7:0]  wr_addr, wr_data;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  bank_m [16];
    logic [15:0] wrq [$];
    logic [15:0] exp_wrq [$];

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        int          n;
        bit          scr;
        logic [63:0] wdat;
        logic [63:0] exp_rd;
        int          nwr;
        logic [31:0] exp_wr;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    accel_spi_responder dut (
        .clk      (clk),
        .reset    (reset),
        .CS       (CS),
        .SCLK     (SCLK),
        .SDI      (SDI),
        .SDO      (SDO),
        .x_data   (x_data),
        .y_data   (y_data),
        .z_data   (z_data),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    // Capture every write strobe as {addr, data}
    always @(negedge clk) if (wr_valid === 1'b1) wrq.push_back({wr_addr, wr_data});

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 0 master: SDI set while SCLK low, SDO sampled at the SCLK rise
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            SDI = tx[7-i];
            wait_clk(Half);
            SCLK = 1'b1;
            rx = {rx[6:0], SDO};
            wait_clk(Half);
            SCLK = 1'b0;
        end
    endtask

    task automatic cs_high();
        wait_clk(Half);
        CS = 1'b1;
        wait_clk(3);
        check("busy_release", {15'd0, busy}, 16'd0);
        check("sdo_idle", {15'd0, SDO}, 16'd0);
        wait_clk(Half);
    endtask

    task automatic scramble();
        x_data = 12'($urandom);
        y_data = 12'($urandom);
        z_data = 12'($urandom);
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [7:0] addr, input int n,
                           input bit scr, input logic [63:0] wdat, output logic [63:0] rd);
        logic [7:0] rx;
        rd = '0;
        CS = 1'b0;
        wait_clk(Half);
        check("busy_framed", {15'd0, busy}, 16'd1);
        spi_bits(cmd, 8, rx);
        spi_bits(addr, 8, rx);
        for (int b = 0; b < n; b++) begin
            if (scr && (b == 0 || b == 2)) scramble();
            spi_bits(wdat[63-8*b -: 8], 8, rx);
            rd[63-8*b -: 8] = rx;
        end
        check("busy_hold", {15'd0, busy}, 16'd1);
        cs_high();
    endtask

    // Register map as seen by a reader, from snapshot values and the bank model
    function automatic logic [7:0] ref_reg(input logic [7:0] a, input logic [11:0] sx,
                                           input logic [11:0] sy, input logic [11:0] sz);
        logic signed [11:0] s;
        int v;
        if (a == 8'h00) return 8'hAD;
        if (a == 8'h02) return 8'hF2;
        if (a >= 8'h0E && a <= 8'h13) begin
            case ((int'(a) - 14) / 2)
                0:       s = sx;
                1:       s = sy;
                default: s = sz;
            endcase
            v = s;
            if (a[0] == 1'b0) return 8'(v & 255);
            return 8'((v >>> 8) & 255);
        end
        if (a >= 8'h20 && a <= 8'h2F) return bank_m[a[3:0]];
        return 8'h00;
    endfunction

    task automatic model_write(input logic [7:0] addr, input int n, input logic [63:0] wdat);
        logic [7:0] a;
        for (int b = 0; b < n; b++) begin
            a = addr + 8'(b);
            exp_wrq.push_back({a, wdat[63-8*b -: 8]});
            if (a >= 8'h20 && a <= 8'h2F) bank_m[a[3:0]] = wdat[63-8*b -: 8];
        end
    endtask

    task automatic compare_wr(input string tag);
        check({tag, "_wr_count"}, 16'(wrq.size()), 16'(exp_wrq.size()));
        for (int k = 0; k < exp_wrq.size(); k++) begin
            if (k < wrq.size()) check($sformatf("%s_wr%0d", tag, k), wrq[k], exp_wrq[k]);
        end
        wrq.delete();
        exp_wrq.delete();
    endtask

    initial begin
        logic [63:0] rd;
        logic [7:0]  rx, a, cmd;
        logic [11:0] sx, sy, sz;
        int          n, kind;

        reset = 1'b1; CS = 1'b1; SCLK = 1'b0; SDI = 1'b0;
        x_data = 12'h812; y_data = 12'h034; z_data = 12'hFFF;
        for (int i = 0; i < 16; i++) bank_m[i] = 8'h00;
        wait_clk(4);
        check("rst_sdo", {15'd0, SDO}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_wr_valid", {15'd0, wr_valid}, 16'd0);
        check("rst_wr_addr", {8'd0, wr_addr}, 16'd0);
        check("rst_wr_data", {8'd0, wr_data}, 16'd0);
        reset = 1'b0;
        wait_clk(6);

        vecs[0] = '{8'h0B, 8'h00, 3, 1'b0, 64'h0, 64'hAD00F20000000000, 0, 32'h0};
        vecs[1] = '{8'h0B, 8'h0E, 6, 1'b1, 64'h0, 64'h12F83400FFFF0000, 0, 32'h0};
        vecs[2] = '{8'h0B, 8'hFF, 2, 1'b0, 64'h0, 64'h00AD000000000000, 0, 32'h0};
        vecs[3] = '{8'h0A, 8'h2F, 2, 1'b0, 64'h5AC3000000000000, 64'h0, 2, 32'h2F5A30C3};
        vecs[4] = '{8'h0B, 8'h2F, 1, 1'b0, 64'h0, 64'h5A00000000000000, 0, 32'h0};
        vecs[5] = '{8'h0B, 8'h30, 1, 1'b0, 64'h0, 64'h0, 0, 32'h0};
        vecs[6] = '{8'h55, 8'h0E, 2, 1'b0, 64'hFFFF000000000000, 64'h0, 0, 32'h0};
        vecs[7] = '{8'h0B, 8'h02, 1, 1'b0, 64'h0, 64'hF200000000000000, 0, 32'h0};

        foreach (vecs[i]) begin
            x_data = 12'h812; y_data = 12'h034; z_data = 12'hFFF;
            run_txn(vecs[i].cmd, vecs[i].addr, vecs[i].n, vecs[i].scr, vecs[i].wdat, rd);
            for (int b = 0; b < vecs[i].n; b++)
                check($sformatf("vec%0d_byte%0d", i, b), {8'd0, rd[63-8*b -: 8]},
                      {8'd0, vecs[i].exp_rd[63-8*b -: 8]});
            for (int k = 0; k < vecs[i].nwr; k++)
                exp_wrq.push_back(vecs[i].exp_wr[31-16*k -: 16]);
            if (vecs[i].cmd == 8'h0A) begin
                for (int b = 0; b < vecs[i].n; b++) begin
                    a = vecs[i].addr + 8'(b);
                    if (a >= 8'h20 && a <= 8'h2F) bank_m[a[3:0]] = vecs[i].wdat[63-8*b -: 8];
                end
            end
            compare_wr($sformatf("vec%0d", i));
        end

        // Abort a write after 5 data bits
        CS = 1'b0;
        wait_clk(Half);
        spi_bits(8'h0A, 8, rx);
        spi_bits(8'h20, 8, rx);
        spi_bits(8'hFF, 5, rx);
        cs_high();
        compare_wr("abort");
        run_txn(8'h0B, 8'h20, 1, 1'b0, 64'h0, rd);
        check("abort_bank", {8'd0, rd[63:56]}, {8'd0, ref_reg(8'h20, 12'h0, 12'h0, 12'h0)});

        // CS release on the same clock as the 8th SCLK rise: write must not happen
        CS = 1'b0;
        wait_clk(Half);
        spi_bits(8'h0A, 8, rx);
        spi_bits(8'h21, 8, rx);
        spi_bits(8'hFF, 7, rx);
        SDI = 1'b1;
        wait_clk(Half);
        SCLK = 1'b1;
        CS = 1'b1;
        wait_clk(Half);
        SCLK = 1'b0;
        wait_clk(3);
        check("race_busy", {15'd0, busy}, 16'd0);
        wait_clk(Half);
        compare_wr("race");
        run_txn(8'h0B, 8'h21, 1, 1'b0, 64'h0, rd);
        check("race_bank", {8'd0, rd[63:56]}, {8'd0, ref_reg(8'h21, 12'h0, 12'h0, 12'h0)});

        // Randomized transactions against the model
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 4);
            case ($urandom_range(0, 3))
                0:       a = 8'($urandom_range(0, 19));
                1:       a = 8'(8'h20 + $urandom_range(0, 15));
                2:       a = 8'(8'hFC + $urandom_range(0, 3));
                default: a = 8'($urandom);
            endcase
            n = $urandom_range(1, 4);
            scramble();
            sx = x_data; sy = y_data; sz = z_data;
            rd = {$urandom, $urandom};
            if (kind < 2) begin
                cmd = 8'h0A;
                model_write(a, n, rd);
            end else if (kind < 4) begin
                cmd = 8'h0B;
            end else begin
                cmd = 8'h55 ^ 8'($urandom_range(0, 7) << 4);
            end
            begin
                logic [63:0] wd;
                wd = rd;
                run_txn(cmd, a, n, 1'b1, wd, rd);
                for (int b = 0; b < n; b++) begin
                    check($sformatf("rnd%0d_byte%0d", t, b), {8'd0, rd[63-8*b -: 8]},
                          {8'd0, (cmd == 8'h0B) ? ref_reg(a + 8'(b), sx, sy, sz) : 8'h00});
                end
            end
            compare_wr($sformatf("rnd%0d", t));
        end

        // Reset in the middle of a read with CS held low
        CS = 1'b0;
        wait_clk(Half);
        spi_bits(8'h0B, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        check("pre_reset_read", {8'd0, rx}, 16'h00AD);
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) bank_m[i] = 8'h00;
        wait_clk(4);
        check("post_reset_sdo", {15'd0, SDO}, 16'd0);
        check("post_reset_busy", {15'd0, busy}, 16'd0);
        spi_bits(8'h0B, 8, rx);
        check("post_reset_rx", {8'd0, rx}, 16'd0);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        check("post_reset_rx2", {8'd0, rx}, 16'd0);
        check("post_reset_busy2", {15'd0, busy}, 16'd0);
        cs_high();
        compare_wr("reset");
        run_txn(8'h0B, 8'h00, 1, 1'b0, 64'h0, rd);
        check("recover_id", {8'd0, rd[63:56]}, 16'h00AD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
